coram_block_sequencer: RTL and testbench



---
 rtl/coram_block_sequencer_pkg.sv | 38 +++
 rtl/coram_block_sequencer_cmd_decode.sv | 35 +++
 rtl/coram_block_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_coram_block_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coram_block_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// coram_block_sequencer_pkg
//   Shared definitions for the CoRAM block sequencer: opcode values, FSM
//   state encoding, command-word field offset helpers and the error reply.
// ---------------------------------------------------------------------------
package coram_block_sequencer_pkg;

  // Command opcodes (op field, top two bits of the command word).
  // Any opcode with bit 1 set (2 or 3) is rejected with the error word.
  localparam logic [1:0] OP_SUM   = 2'd0;
  localparam logic [1:0] OP_CLEAR = 2'd1;

  // FSM state encoding.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] REPLY = 3'd4;

  // Reply for a rejected opcode: all-ones, sliced down to the data width.
  localparam int         ERR_WORD_MAX_W = 64;
  localparam logic [63:0] ERR_WORD      = '1;

  // Command word layout, low to high: len [W_A-1:0], base [2W_A-1:W_A],
  // unused padding, op [W_D-1:W_D-2].
  function automatic int cmd_len_msb(input int w_a);
    return w_a - 1;
  endfunction

  function automatic int cmd_base_lsb(input int w_a);
    return w_a;
  endfunction

  function automatic int cmd_base_msb(input int w_a);
    return 2 * w_a - 1;
  endfunction

endpackage

// File: rtl/coram_block_sequencer_cmd_decode.sv
// ---------------------------------------------------------------------------
// coram_block_sequencer_cmd_decode
//   Purely combinational split of a channel command word.
//   Ports:
//     cmd_word  in   W_D  raw command word from the channel
//     op        out  2    opcode
//     base      out  W_A  first memory address
//     len       out  W_A  number of words to process
//     bad_op    out  1    opcode is neither SUM nor CLEAR
// ---------------------------------------------------------------------------
module coram_block_sequencer_cmd_decode
  import coram_block_sequencer_pkg::*;
#(
  parameter int W_A = 10,
  parameter int W_D = 32
) (
  input  logic [W_D-1:0] cmd_word,
  output logic [1:0]     op,
  output logic [W_A-1:0] base,
  output logic [W_A-1:0] len,
  output logic           bad_op
);

  assign op     = cmd_word[W_D-1 -: 2];
  assign base   = cmd_word[cmd_base_msb(W_A):cmd_base_lsb(W_A)];
  assign len    = cmd_word[cmd_len_msb(W_A):0];
  assign bad_op = op[1];

  // Bits between the base field and the opcode carry no meaning.
  if (W_D - 2 > 2 * W_A) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^cmd_word[W_D-3:2*W_A];
  end

endmodule

// File: rtl/coram_block_sequencer.sv
// ---------------------------------------------------------------------------
// coram_block_sequencer
//   Drives one CoRAM single-port memory and one CoRAM channel. Pops a
//   command, runs a SUM or CLEAR over base..base+len-1 (addresses wrap
//   modulo 2^W_A) and pushes exactly one reply word per command.
//   Ports:
//     CLK, RST     clock, synchronous active-high reset
//     mem_addr     out  W_A  memory address (registered)
//     mem_d        out  W_D  memory write data (always 0; only CLEAR writes)
//     mem_we       out  1    memory write enable, high only in RUN of CLEAR
//     mem_q        in   W_D  read data, valid the cycle after mem_addr
//     comm_d       out  W_D  reply word
//     comm_enq     out  1    one-cycle reply push
//     comm_full    in   1    channel cannot take a reply
//     comm_q       in   W_D  command word, captured in FETCH (the cycle in
//                            which the registered comm_deq pulse is high)
//     comm_deq     out  1    one-cycle command pop
//     comm_empty   in   1    no command pending
//     busy         out  1    FSM is not in IDLE
//     cmd_count    out  16   completed commands, wrapping
// ---------------------------------------------------------------------------
module coram_block_sequencer
  import coram_block_sequencer_pkg::*;
#(
  parameter int W_A = 10,
  parameter int W_D = 32
) (
  input  logic           CLK,
  input  logic           RST,
  output logic [W_A-1:0] mem_addr,
  output logic [W_D-1:0] mem_d,
  output logic           mem_we,
  input  logic [W_D-1:0] mem_q,
  output logic [W_D-1:0] comm_d,
  output logic           comm_enq,
  input  logic           comm_full,
  input  logic [W_D-1:0] comm_q,
  output logic           comm_deq,
  input  logic           comm_empty,
  output logic           busy,
  output logic [15:0]    cmd_count
);

  if (W_D < 2 * W_A + 2) begin : g_width_check
    $error("coram_block_sequencer: W_D must be at least 2*W_A+2");
  end
  if (W_D > ERR_WORD_MAX_W) begin : g_err_width_check
    $error("coram_block_sequencer: W_D wider than the error word");
  end

  localparam logic [W_D-1:0] ERR_RESULT = ERR_WORD[W_D-1:0];

  // Decoded command fields (meaningful only in FETCH).
  logic [1:0]     cmd_op;
  logic [W_A-1:0] cmd_base;
  logic [W_A-1:0] cmd_len;
  logic           cmd_bad_op;

  coram_block_sequencer_cmd_decode #(
    .W_A (W_A),
    .W_D (W_D)
  ) u_cmd_decode (
    .cmd_word (comm_q),
    .op       (cmd_op),
    .base     (cmd_base),
    .len      (cmd_len),
    .bad_op   (cmd_bad_op)
  );

  // Internal state.
  logic [2:0]     state_q,    state_d;
  logic           is_clear_q, is_clear_d;
  logic [W_A-1:0] base_q,     base_d;
  logic [W_A-1:0] len_q,      len_d;
  logic [W_A-1:0] idx_q,      idx_d;
  logic [W_D-1:0] acc_q,      acc_d;
  logic [W_D-1:0] result_q,   result_d;
  logic           rd_valid_q, rd_valid_d;

  // Registered outputs.
  logic [W_A-1:0] mem_addr_q,  mem_addr_d;
  logic [W_D-1:0] mem_d_q,     mem_d_d;
  logic           mem_we_q,    mem_we_d;
  logic [W_D-1:0] comm_d_q,    comm_d_d;
  logic           comm_enq_q,  comm_enq_d;
  logic           comm_deq_q,  comm_deq_d;
  logic           busy_q,      busy_d;
  logic [15:0]    cmd_count_q, cmd_count_d;

  logic last_idx;
  assign last_idx = (idx_q == len_q - W_A'(1));

  always_comb begin
    state_d     = state_q;
    is_clear_d  = is_clear_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    result_d    = result_q;
    rd_valid_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_d_d     = '0;
    mem_we_d    = mem_we_q;
    comm_d_d    = comm_d_q;
    comm_enq_d  = 1'b0;
    comm_deq_d  = 1'b0;
    cmd_count_d = cmd_count_q;

    // Read data returns one cycle after each SUM address, so the add
    // trails the address stream by one cycle.
    if (rd_valid_q) begin
      acc_d = acc_q + mem_q;
    end

    case (state_q)
      IDLE: begin
        if (!comm_empty) begin
          comm_deq_d = 1'b1;
          state_d    = FETCH;
        end
      end

      FETCH: begin
        is_clear_d = (cmd_op == OP_CLEAR);
        base_d     = cmd_base;
        len_d      = cmd_len;
        idx_d      = '0;
        acc_d      = '0;
        if (cmd_bad_op) begin
          result_d = ERR_RESULT;
          state_d  = REPLY;
        end else if (cmd_len == '0) begin
          result_d = '0;
          state_d  = REPLY;
        end else begin
          // Address and write enable are registered, so the first address
          // is loaded here to line up with the first RUN cycle.
          mem_addr_d = cmd_base;
          mem_we_d   = (cmd_op == OP_CLEAR);
          state_d    = RUN;
        end
      end

      RUN: begin
        rd_valid_d = !is_clear_q;
        if (last_idx) begin
          mem_we_d = 1'b0;
          if (is_clear_q) begin
            result_d = {{(W_D-W_A){1'b0}}, len_q};
            state_d  = REPLY;
          end else begin
            state_d  = DRAIN;
          end
        end else begin
          idx_d      = idx_q + W_A'(1);
          mem_addr_d = base_q + idx_q + W_A'(1);
        end
      end

      DRAIN: begin
        // Final read word arrives now; fold it straight into the result.
        result_d = acc_q + mem_q;
        state_d  = REPLY;
      end

      REPLY: begin
        if (!comm_full) begin
          comm_d_d    = result_q;
          comm_enq_d  = 1'b1;
          cmd_count_d = cmd_count_q + 16'd1;
          state_d     = IDLE;
        end
      end

      default: begin
        mem_we_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      is_clear_q  <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      rd_valid_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_d_q     <= '0;
      mem_we_q    <= 1'b0;
      comm_d_q    <= '0;
      comm_enq_q  <= 1'b0;
      comm_deq_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_count_q <= '0;
    end else begin
      state_q     <= state_d;
      is_clear_q  <= is_clear_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      rd_valid_q  <= rd_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_d_q     <= mem_d_d;
      mem_we_q    <= mem_we_d;
      comm_d_q    <= comm_d_d;
      comm_enq_q  <= comm_enq_d;
      comm_deq_q  <= comm_deq_d;
      busy_q      <= busy_d;
      cmd_count_q <= cmd_count_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_d     = mem_d_q;
  assign mem_we    = mem_we_q;
  assign comm_d    = comm_d_q;
  assign comm_enq  = comm_enq_q;
  assign comm_deq  = comm_deq_q;
  assign busy      = busy_q;
  assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_coram_block_sequencer.sv
// ---------------------------------------------------------------------------
// tb_coram_block_sequencer
//   Self-checking bench: behavioural CoRAM memory (registered read) and a
//   show-ahead command channel around the sequencer. Expected replies are
//   queued when a command is pushed and compared when comm_enq fires.
// ---------------------------------------------------------------------------
module tb_coram_block_sequencer;

  logic        clk = 1'b0;
  logic        RST;
  logic [9:0]  mem_addr;
  logic [31:0] mem_d;
  logic        mem_we;
  logic [31:0] mem_q;
  logic [31:0] comm_d;
  logic        comm_enq;
  logic        comm_full;
  logic [31:0] comm_q;
  logic        comm_deq;
  logic        comm_empty;
  logic        busy;
  logic [15:0] cmd_count;

  always #5 clk = ~clk;

  coram_block_sequencer #(.W_A(10), .W_D(32)) dut (
    .CLK        (clk),
    .RST        (RST),
    .mem_addr   (mem_addr),
    .mem_d      (mem_d),
    .mem_we     (mem_we),
    .mem_q      (mem_q),
    .comm_d     (comm_d),
    .comm_enq   (comm_enq),
    .comm_full  (comm_full),
    .comm_q     (comm_q),
    .comm_deq   (comm_deq),
    .comm_empty (comm_empty),
    .busy       (busy),
    .cmd_count  (cmd_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory model (registered read) ----------------
  logic [31:0] mem [1024];
  logic        tb_we = 1'b0;
  logic [9:0]  tb_addr = '0;
  logic [31:0] tb_data = '0;

  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (mem_we) mem[mem_addr] <= mem_d;
    mem_q <= mem[mem_addr];
  end

  // ---------------- command channel (show-ahead) ----------------
  logic [31:0] cmd_mem [64];
  int cmd_wr = 0;
  int cmd_rd = 0;
  assign comm_empty = (cmd_wr == cmd_rd);
  assign comm_q     = cmd_mem[cmd_rd[5:0]];

  always @(posedge clk) begin
    if (RST) cmd_rd <= cmd_rd;
    else if (comm_deq && (cmd_wr != cmd_rd)) cmd_rd <= cmd_rd + 1;
  end

  // ---------------- scoreboard and monitors ----------------
  typedef struct {
    logic [31:0] data;
    int          lat;   // -1: latency not checked
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0]  wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [9:0]  prev_addr = '0;
  int addr_chg = 0;
  int deq_total = 0;
  int enq_total = 0;
  int last_deq_cyc = 0;
  int last_enq_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (mem_we) begin
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_d);
      check("we_only_while_busy", {63'd0, busy}, 64'd1);
    end
    if (mem_addr != prev_addr) addr_chg++;
    prev_addr = mem_addr;
    if (comm_deq) begin
      deq_total++;
      last_deq_cyc = cyc;
    end
    if (comm_enq) begin
      enq_total++;
      last_enq_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_enq: got comm_d=0x%08h, required no reply", comm_d);
      end else begin
        e = sb.pop_front();
        check("reply_data", {32'd0, comm_d}, {32'd0, e.data});
        check("reply_count", {48'd0, cmd_count}, {48'd0, 16'(enq_total)});
        if (e.lat >= 0) check("reply_latency", 64'(cyc - last_deq_cyc), 64'(e.lat));
        $display("reply %0d: comm_d=0x%08h cmd_count=%0d expected=0x%08h", enq_total, comm_d, cmd_count, e.data);
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] mk_cmd(input logic [1:0] op, input logic [9:0] base, input logic [9:0] len);
    return {op, 10'd0, base, len};
  endfunction

  task automatic push_cmd(input logic [31:0] w);
    cmd_mem[cmd_wr[5:0]] = w;
    cmd_wr = cmd_wr + 1;
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    tb_we = 1'b1;
    tb_addr = a;
    tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic wait_replies(input int target, input string name);
    int n = 0;
    while ((enq_total < target || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check({name, "_timeout"}, 64'(enq_total), 64'(target));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_mem_addr"},  {54'd0, mem_addr}, 64'd0);
    check({name, "_mem_d"},     {32'd0, mem_d},    64'd0);
    check({name, "_mem_we"},    {63'd0, mem_we},   64'd0);
    check({name, "_comm_d"},    {32'd0, comm_d},   64'd0);
    check({name, "_comm_enq"},  {63'd0, comm_enq}, 64'd0);
    check({name, "_comm_deq"},  {63'd0, comm_deq}, 64'd0);
    check({name, "_busy"},      {63'd0, busy},     64'd0);
    check({name, "_cmd_count"}, {48'd0, cmd_count}, 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [9:0]  base;
    logic [9:0]  len;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  localparam int NV = 13;
  vec_t vecs[NV];

  initial begin
    int n;
    int nw;
    int a0;
    int n0;
    int d0;
    int e1;
    logic no_access;

    // memory {0..3}=1,2,3,4  {100,101}=FFFFFFFF,2  {1020..1023}=5,6,7,8
    vecs[0]  = '{2'd0, 10'd0,    10'd4, 32'd10,         7};
    vecs[1]  = '{2'd0, 10'd100,  10'd2, 32'd1,          5};
    vecs[2]  = '{2'd0, 10'd1020, 10'd6, 32'd29,         9};
    vecs[3]  = '{2'd1, 10'd1020, 10'd6, 32'd6,          8};
    vecs[4]  = '{2'd0, 10'd1020, 10'd6, 32'd0,          9};
    vecs[5]  = '{2'd0, 10'd0,    10'd4, 32'd7,          7};
    vecs[6]  = '{2'd0, 10'd5,    10'd0, 32'd0,          2};
    vecs[7]  = '{2'd3, 10'd1,    10'd4, 32'hFFFF_FFFF,  2};
    vecs[8]  = '{2'd2, 10'd0,    10'd0, 32'hFFFF_FFFF,  2};
    vecs[9]  = '{2'd1, 10'd2,    10'd1, 32'd1,          3};
    vecs[10] = '{2'd0, 10'd2,    10'd2, 32'd4,          5};
    vecs[11] = '{2'd1, 10'd3,    10'd0, 32'd0,          2};
    vecs[12] = '{2'd0, 10'd3,    10'd1, 32'd4,          4};

    RST = 1'b1;
    comm_full = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    RST = 1'b0;

    // ---- reset in the middle of a CLEAR run ----
    for (int a = 10; a < 18; a++) poke(10'(a), 32'd9);
    push_cmd(mk_cmd(2'd1, 10'd10, 10'd8));
    n = 0;
    while (!mem_we && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_run", {63'd0, mem_we}, 64'd1);
    repeat (2) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    RST = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_reply", 64'(enq_total), 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_cmd_count", {48'd0, cmd_count}, 64'd0);
    check("abort_first_cleared", {32'd0, mem[10]}, 64'd0);
    check("abort_tail_kept", {32'd0, mem[17]}, 64'd9);
    $display("abort: reset mid-CLEAR, enq_total=%0d busy=%0d", enq_total, busy);

    // ---- table-driven commands ----
    for (int a = 0; a < 4; a++) poke(10'(a), 32'(a + 1));
    poke(10'd100, 32'hFFFF_FFFF);
    poke(10'd101, 32'd2);
    for (int a = 0; a < 4; a++) poke(10'(1020 + a), 32'(5 + a));

    for (int v = 0; v < NV; v++) begin
      wr_addr_log.delete();
      wr_data_log.delete();
      a0 = addr_chg;
      n0 = enq_total;
      sb.push_back('{vecs[v].exp, vecs[v].lat});
      push_cmd(mk_cmd(vecs[v].op, vecs[v].base, vecs[v].len));
      wait_replies(n0 + 1, "vec");
      no_access = vecs[v].op[1] || (vecs[v].len == 10'd0);
      nw = (vecs[v].op == 2'd1 && vecs[v].len != 10'd0) ? int'(vecs[v].len) : 0;
      check("vec_write_count", 64'(wr_addr_log.size()), 64'(nw));
      for (int k = 0; k < nw && k < wr_addr_log.size(); k++) begin
        check("vec_write_addr", {54'd0, wr_addr_log[k]}, {54'd0, 10'(vecs[v].base + 10'(k))});
        check("vec_write_data", {32'd0, wr_data_log[k]}, 64'd0);
      end
      if (no_access) check("vec_addr_static", 64'(addr_chg - a0), 64'd0);
      $display("vector %0d: op=%0d base=%0d len=%0d expected=0x%08h writes=%0d",
               v, vecs[v].op, vecs[v].base, vecs[v].len, vecs[v].exp, wr_addr_log.size());
    end

    // ---- reply held off by comm_full (mem 0..3 now 0,0,0,4) ----
    comm_full = 1'b1;
    n0 = enq_total;
    sb.push_back('{32'd4, -1});
    push_cmd(mk_cmd(2'd0, 10'd0, 10'd4));
    n = 0;
    while (!comm_deq && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("full_deq_seen", {63'd0, comm_deq}, 64'd1);
    repeat (6) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("full_enq_held", {63'd0, comm_enq}, 64'd0);
      check("full_busy", {63'd0, busy}, 64'd1);
      @(negedge clk);
    end
    check("full_enq_still_held", {63'd0, comm_enq}, 64'd0);
    comm_full = 1'b0;
    @(negedge clk);
    check("full_enq_on_release", {63'd0, comm_enq}, 64'd1);
    check("full_cmd_count", {48'd0, cmd_count}, 64'(n0 + 1));
    @(negedge clk);
    check("full_enq_single", {63'd0, comm_enq}, 64'd0);
    check("full_enq_total", 64'(enq_total), 64'(n0 + 1));
    $display("full: reply released after hold, cmd_count=%0d", cmd_count);

    // ---- two commands queued together ----
    n0 = enq_total;
    d0 = deq_total;
    sb.push_back('{32'd1, 5});
    sb.push_back('{32'd4, 4});
    push_cmd(mk_cmd(2'd0, 10'd100, 10'd2));
    push_cmd(mk_cmd(2'd0, 10'd3, 10'd1));
    wait_replies(n0 + 1, "pair_first");
    e1 = last_enq_cyc;
    wait_replies(n0 + 2, "pair_second");
    check("pair_deq_count", 64'(deq_total - d0), 64'd2);
    check("pair_deq_after_enq", {63'd0, last_deq_cyc > e1}, 64'd1);
    check("pair_sb_empty", 64'(sb.size()), 64'd0);
    $display("pair: first enq cycle %0d, second deq cycle %0d", e1, last_deq_cyc);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
